// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: debounced button front end and game state / song selection controller
module game_flow_ctrl #(
  parameter int N_BTN         = 3,
  parameter int DEB_CYCLES    = 4,
  parameter int N_SONGS       = 3,
  parameter int SEL_W         = 2,
  parameter int WRAP          = 1,
  parameter int COUNTDOWN_CYC = 16,
  parameter int IDLE_TIMEOUT  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             finish,
  input  logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] btn_pulse,
  output logic [SEL_W-1:0] song_select,
  output logic [SEL_W-1:0] song_confirm,
  output logic [2:0]       state
);
  typedef enum logic [2:0] {START, MENU, COUNTDOWN, PLAY, PAUSE, FINISH} state_t;
  localparam int DW   = $clog2(DEB_CYCLES + 1);
  localparam int CMAX = (COUNTDOWN_CYC > IDLE_TIMEOUT) ? COUNTDOWN_CYC : IDLE_TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);
  logic [N_BTN-1:0] s1, s2, deb, deb_d;
  logic [DW-1:0]    dcnt [N_BTN];
  state_t           st, nxt;
  logic [CW-1:0]    cnt;
  logic [SEL_W-1:0] sel_dn, sel_up;
  logic             p, n, c;
  assign p     = btn_pulse[0];
  assign n     = btn_pulse[1];
  assign c     = btn_pulse[2];
  assign state = st;
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1        <= '0;
      s2        <= '0;
      deb       <= '0;
      deb_d     <= '0;
      btn_pulse <= '0;
      for (int i = 0; i < N_BTN; i++) dcnt[i] <= '0;
    end else begin
      s1        <= btn;
      s2        <= s1;
      deb_d     <= deb;
      btn_pulse <= deb & ~deb_d;
      for (int i = 0; i < N_BTN; i++)
        if (s2[i] == deb[i]) dcnt[i] <= '0;
        else if (dcnt[i] == DW'(DEB_CYCLES - 1)) begin
          dcnt[i] <= '0;
          deb[i]  <= ~deb[i];
        end else dcnt[i] <= dcnt[i] + 1'b1;
    end
  end
  // prev beats countdown expiry, finish beats confirm, confirm beats idle expiry
  always_comb begin
    nxt = START;
    case (st)
      START:     nxt = |btn_pulse ? MENU : START;
      MENU:      nxt = c ? COUNTDOWN : MENU;
      COUNTDOWN: nxt = p ? MENU : (cnt == CW'(COUNTDOWN_CYC - 1)) ? PLAY : COUNTDOWN;
      PLAY:      nxt = finish ? FINISH : c ? PAUSE : PLAY;
      PAUSE:     nxt = c ? PLAY : p ? MENU : PAUSE;
      FINISH:    nxt = c ? MENU :
                       (IDLE_TIMEOUT != 0 && cnt == CW'(IDLE_TIMEOUT - 1)) ? START : FINISH;
      default:   nxt = START;
    endcase
  end
  always_comb begin
    sel_dn = (song_select == SEL_W'(1)) ? ((WRAP != 0) ? SEL_W'(N_SONGS) : SEL_W'(1))
                                        : song_select - 1'b1;
    sel_up = (song_select == SEL_W'(N_SONGS)) ? ((WRAP != 0) ? SEL_W'(1) : SEL_W'(N_SONGS))
                                              : song_select + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      st           <= START;
      cnt          <= '0;
      song_select  <= SEL_W'(1);
      song_confirm <= '0;
    end else begin
      st           <= nxt;
      cnt          <= (nxt != st) ? '0 : cnt + 1'b1;
      song_confirm <= (st == MENU && c) ? song_select : '0;
      if (st == MENU && (p ^ n) && !c) song_select <= p ? sel_dn : sel_up;
    end
  end
endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: randomized scoreboard bench for a wrapping and a saturating game_flow_ctrl
module tb_game_flow_ctrl;
  localparam int NB  = 4;
  localparam int DEB = 4;
  localparam int NS  = 3;
  localparam int CD  = 16;
  localparam int IDL = 8;
  logic clk, rst, finish;
  logic [NB-1:0] btn, pa, pb;
  logic [1:0] sa, sb, ca, cb;
  logic [2:0] sta, stb;
  typedef struct {
    int st;
    int sa;
    int sb;
    int ca;
    int cb;
    logic [NB-1:0] pulse;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  logic [NB-1:0] rq[$];
  logic [NB-1:0] m_lev, m_lev_d, m_pulse;
  int m_st, m_t, m_sa, m_sb, m_ca, m_cb;

  game_flow_ctrl #(.N_BTN(NB), .DEB_CYCLES(DEB), .N_SONGS(NS), .SEL_W(2), .WRAP(1),
                   .COUNTDOWN_CYC(CD), .IDLE_TIMEOUT(IDL)) dut_a (
    .clk(clk), .rst(rst), .finish(finish), .btn(btn),
    .btn_pulse(pa), .song_select(sa), .song_confirm(ca), .state(sta));
  game_flow_ctrl #(.N_BTN(NB), .DEB_CYCLES(DEB), .N_SONGS(NS), .SEL_W(2), .WRAP(0),
                   .COUNTDOWN_CYC(CD), .IDLE_TIMEOUT(IDL)) dut_b (
    .clk(clk), .rst(rst), .finish(finish), .btn(btn),
    .btn_pulse(pb), .song_select(sb), .song_confirm(cb), .state(stb));

  initial clk = 0;
  always #5 clk = ~clk;

  // Reference: a level flips once the synchronised input (raw delayed two edges)
  // has disagreed with it for DEB consecutive samples.
  task automatic model(input logic r, input logic [NB-1:0] b, input logic f);
    logic [NB-1:0] flip;
    logic p, n, c;
    int nst;
    if (!r) begin
      rq = {};
      repeat (DEB + 2) rq.push_back('0);
      m_lev = '0; m_lev_d = '0; m_pulse = '0;
      m_st = 0; m_t = 0; m_sa = 1; m_sb = 1; m_ca = 0; m_cb = 0;
      return;
    end
    p = m_pulse[0]; n = m_pulse[1]; c = m_pulse[2];
    rq.push_back(b);
    void'(rq.pop_front());
    flip = '1;
    for (int j = 0; j < DEB; j++) flip &= rq[j] ^ m_lev;
    m_ca = (m_st == 1 && c) ? m_sa : 0;
    m_cb = (m_st == 1 && c) ? m_sb : 0;
    if (m_st == 1 && (p ^ n) && !c) begin
      m_sa = ((m_sa - 1 + (n ? 1 : -1) + NS) % NS) + 1;
      m_sb = n ? ((m_sb < NS) ? m_sb + 1 : NS) : ((m_sb > 1) ? m_sb - 1 : 1);
    end
    case (m_st)
      0: nst = (m_pulse != 0) ? 1 : 0;
      1: nst = c ? 2 : 1;
      2: nst = p ? 1 : (m_t + 1 == CD) ? 3 : 2;
      3: nst = f ? 5 : c ? 4 : 3;
      4: nst = c ? 3 : p ? 1 : 4;
      5: nst = c ? 1 : (m_t + 1 == IDL) ? 0 : 5;
      default: nst = 0;
    endcase
    m_t = (nst == m_st) ? m_t + 1 : 0;
    m_st = nst;
    m_pulse = m_lev & ~m_lev_d;
    m_lev_d = m_lev;
    m_lev = m_lev ^ flip;
  endtask

  task automatic step(input logic r, input logic [NB-1:0] b, input logic f);
    exp_t e;
    @(negedge clk);
    rst = r; btn = b; finish = f;
    model(r, b, f);
    e.st = m_st; e.sa = m_sa; e.sb = m_sb; e.ca = m_ca; e.cb = m_cb; e.pulse = m_pulse;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("state_a", 8'(sta), 8'(e.st));
      chk("state_b", 8'(stb), 8'(e.st));
      chk("select_wrap", 8'(sa), 8'(e.sa));
      chk("select_sat", 8'(sb), 8'(e.sb));
      chk("confirm_wrap", 8'(ca), 8'(e.ca));
      chk("confirm_sat", 8'(cb), 8'(e.cb));
      chk("pulse_a", 8'(pa), 8'(e.pulse));
      chk("pulse_b", 8'(pb), 8'(e.pulse));
    end
  end

  initial begin
    logic [NB-1:0] mask;
    logic f;
    int sel;
    rst = 0; btn = '0; finish = 0;
    repeat (3) step(0, '0, 0);
    repeat (2) step(1, 4'b0001, 0);
    repeat (8) step(1, '0, 0);
    repeat (10) step(1, 4'b0001, 0);
    repeat (6) step(1, '0, 0);
    for (int k = 0; k < 1200; k++) begin
      sel = $urandom_range(0, 9);
      mask = (sel <= 2) ? 4'b0100 : (sel <= 4) ? 4'b0010 : (sel <= 6) ? 4'b0001 :
             (sel == 7) ? 4'b1000 : 4'($urandom_range(0, 15));
      f = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 60) == 0) repeat ($urandom_range(1, 2)) step(0, mask, f);
      repeat ($urandom_range(1, 12)) step(1, mask, f);
      repeat ($urandom_range(1, 30)) step(1, '0, f);
    end
    @(posedge clk);
    #2;
    chk("scoreboard_drained", 8'(q.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
- Parametrised successor to the three-button game-state controller; it sits between the raw panel buttons and the LED-matrix game engine / song player.
- Adds per-button synchronisation and debounce, a configurable button count, and a configurable song count with wrap or saturate selection.
- Adds COUNTDOWN and PAUSE states and an optional FINISH idle timeout back to START.

Parameters:
- N_BTN, 3, number of buttons (>=3). Bit0 = prev/back (red), bit1 = next (blue), bit2 = confirm (yellow). Bits 3+ only wake from START and appear on btn_pulse.
- DEB_CYCLES, 4, consecutive stable synchronised cycles required to change a debounced level (>=1).
- N_SONGS, 3, number of selectable songs, numbered 1..N_SONGS (1 <= N_SONGS < 2**SEL_W).
- SEL_W, 2, width of the song number; value 0 means "no song".
- WRAP, 1, 1 = prev/next wrap between 1 and N_SONGS; 0 = saturate at the ends.
- COUNTDOWN_CYC, 16, cycles spent in COUNTDOWN before PLAY (>=1).
- IDLE_TIMEOUT, 0, cycles in FINISH with no confirm before returning to START; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- finish  in  1  level from game engine, song complete
- btn  in  N_BTN  raw asynchronous buttons, active-high
- btn_pulse  out  N_BTN  one-cycle registered press pulses, debounced
- song_select  out  SEL_W  currently highlighted song
- song_confirm  out  SEL_W  one-cycle song number on start of COUNTDOWN, else 0
- state  out  3  registered current state

Behaviour:
- Reset (rst==0 at a clk edge): state=START(0), song_select=1, song_confirm=0, btn_pulse=0, sync flops=0, debounced levels=0, all counters=0.
  - A button held through reset produces one pulse after release of reset, once debounced.
- Input path, per bit:
  - 2-flop synchroniser, then debounce counter.
  - The counter increments while the synced value differs from the debounced level and clears when they match.
  - When it reaches DEB_CYCLES, the debounced level flips and the counter clears.
  - btn_pulse[i] = registered rising edge of the debounced level, high exactly 1 cycle.
  - Latency: raw 0->1 held steady gives btn_pulse high in cycle DEB_CYCLES+3 after the first sampling edge.
  - Glitches shorter than DEB_CYCLES produce no pulse.
- Pulses are consumed by the FSM in the cycle they are high. P = prev pulse, N = next pulse, C = confirm pulse.
- States:
  - START=0: any btn_pulse bit -> MENU.
  - MENU=1: C -> COUNTDOWN; song_confirm <= song_select for that one cycle, so it is high the first cycle state==2.
  - COUNTDOWN=2: counter counts cycles in state; on COUNTDOWN_CYC-th cycle -> PLAY. P -> MENU (abort), and P has priority over expiry.
  - PLAY=3: finish -> FINISH; else C -> PAUSE. finish has priority over C.
  - PAUSE=4: C -> PLAY; P -> MENU (quit). C and P together -> PLAY. finish is ignored.
  - FINISH=5:
    - C -> MENU.
    - If IDLE_TIMEOUT>0, after IDLE_TIMEOUT consecutive cycles without C -> START.
    - C wins on the expiry cycle.
- Counters clear on every state change.
- Encodings 6,7 are unreachable; if entered, go to START next cycle.
- song_select updates only in MENU and only when exactly one of P/N is high and C is low:
  - P decrements; N increments.
  - At 1, P gives N_SONGS (WRAP=1) or stays 1 (WRAP=0).
  - At N_SONGS, N gives 1 (WRAP=1) or stays N_SONGS (WRAP=0).
  - P and N together, or either together with C: no change.
  - song_select never equals 0 or exceeds N_SONGS.
  - It is retained across PLAY/FINISH, so returning to MENU keeps the last song.
- All outputs registered; no combinational path from btn or finish to any output.
- Reset mid-operation (any state, any counter value) returns to reset values on the next edge.

Test Plan:
- Reset, then raw btn[0] high 2 cycles with DEB_CYCLES=4 -> no btn_pulse. Hold it 10 cycles -> btn_pulse[0] high exactly once, at cycle 7.
- From START, press btn[3] (N_BTN=4) -> state 0->1. Press next twice with N_SONGS=3, WRAP=1 -> song_select 1->2->3. Press next again -> 1. Press prev -> 3.
- WRAP=0: at song_select=1 press prev -> stays 1. Pulse prev and next in the same cycle -> unchanged.
- MENU with song_select=2, press confirm -> song_confirm=2 for exactly 1 cycle, state=2. PLAY follows after COUNTDOWN_CYC=16 cycles. Repeat with prev pressed mid-countdown -> state=1, song_confirm never reasserted.
- PLAY: confirm -> state=4. Assert finish in PAUSE -> stays 4. Confirm -> 3. Assert finish and confirm together -> 5.
- FINISH with IDLE_TIMEOUT=8, no presses -> state=0 after 8 cycles. Confirm at cycle 3 -> state=1. rst low during COUNTDOWN -> state=0, song_select=1 next edge.
